p405s_dcd_br_hazard: RTL and testbench

- Hazard/interlock stage directly downstream of the branch decode PLA (plaCr0En, plaB, plaBc, plaMtspr).
- Tracks in-flight CR0 writers and LR/CTR mtspr writers through EXE and WB.
- Stalls decode of a conditional branch that consumes a not-yet-written CR0 or LR/CTR, and grants early branch resolution when no hazard exists.
- Also keeps a saturating branch-stall performance counter.

---
 rtl/p405s_dcd_pkg.sv | 32 +++
 rtl/p405s_dcd_sat_cnt.sv | 33 +++
 rtl/p405s_dcd_br_hazard.sv | 107 ++++++++++
 tb/tb_p405s_dcd_br_hazard.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p405s_dcd_pkg.sv
// Shared types for the decode branch-hazard stage: stall-reason encodings
// and the per-stage in-flight writer record.
package p405s_dcd_pkg;

    // Encodings are visible on stallReason, so they are pinned explicitly.
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_WAIT_CR  = 2'b01,
        ST_WAIT_SPR = 2'b10
    } stall_state_e;

    // One pipeline slot: valid, writes CR0, writes LR/CTR via mtspr.
    typedef struct packed {
        logic v;
        logic cr0;
        logic spr;
    } pipe_entry_t;

    localparam pipe_entry_t PIPE_EMPTY = '{v: 1'b0, cr0: 1'b0, spr: 1'b0};

    // CR0 waits outrank LR/CTR waits when both hazards are present.
    function automatic stall_state_e stall_cause(input logic stall,
                                                 input logic cr_haz);
        if (!stall)
            return ST_RUN;
        else if (cr_haz)
            return ST_WAIT_CR;
        else
            return ST_WAIT_SPR;
    endfunction

endpackage

// File: rtl/p405s_dcd_sat_cnt.sv
// Saturating up-counter with increment enable; holds at all-ones.
module p405s_dcd_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step by one unless already saturated.
    always_comb begin
        // NOTE: assign a default before any conditional update so no path leaves cnt_d unassigned and no latch is inferred.
        cnt_d = cnt_q;
        if (inc_en && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + W'(1);
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/p405s_dcd_br_hazard.sv
// Branch interlock for decode: tracks CR0 and LR/CTR writers in EXE/WB,
// stalls a conditional branch that reads a pending value, grants early
// branch resolution otherwise, and counts stall cycles.
module p405s_dcd_br_hazard
    import p405s_dcd_pkg::*;
#(
    parameter int CR_BYPASS = 0,
    parameter int CNT_W     = 8
) (
    input  logic             CB,
    input  logic             resetCore_n,
    input  logic             dcdValid,
    input  logic             plaCr0En,
    input  logic             plaB,
    input  logic             plaBc,
    input  logic             plaMtspr,
    input  logic             dcdSprLrCtr,
    input  logic             dcdBcTestCr,
    input  logic             dcdBcUseLrCtr,
    input  logic             exeHold,
    input  logic             exeFlush,
    output logic             dcdAdvance,
    output logic             dcdBrStall,
    output logic             brResolveOk,
    output logic [1:0]       stallReason,
    output logic             exeCr0Busy,
    output logic             exeLrCtrBusy,
    output logic [CNT_W-1:0] brStallCnt
);

    // With bypass, a CR0 result sitting in WB is forwarded to the branch.
    localparam logic WB_CR_STALLS = (CR_BYPASS == 0);

    pipe_entry_t  exe_q, exe_d;
    pipe_entry_t  wb_q,  wb_d;
    stall_state_e state_q, state_d;

    logic cr_haz;
    logic spr_haz;

    // Hazard detection and decode handshake, zero-cycle from decode inputs.
    always_comb begin
        cr_haz      = dcdBcTestCr &
                      ((exe_q.v & exe_q.cr0) | (wb_q.v & wb_q.cr0 & WB_CR_STALLS));
        spr_haz     = dcdBcUseLrCtr &
                      ((exe_q.v & exe_q.spr) | (wb_q.v & wb_q.spr));
        dcdBrStall  = dcdValid & plaBc & (cr_haz | spr_haz);
        dcdAdvance  = dcdValid & ~dcdBrStall & ~exeHold & ~exeFlush;
        brResolveOk = dcdValid & ~exeFlush & ~dcdBrStall & (plaB | plaBc);
    end

    // EXE/WB slot movement and stall-cause next state.
    always_comb begin
        exe_d   = PIPE_EMPTY;
        wb_d    = wb_q;
        state_d = stall_cause(dcdBrStall, cr_haz);

        if (dcdAdvance) begin
            exe_d.v   = 1'b1;
            exe_d.cr0 = plaCr0En;
            exe_d.spr = plaMtspr & dcdSprLrCtr;
        end else if (exeFlush) begin
            exe_d = PIPE_EMPTY;
        end else if (exeHold) begin
            exe_d = exe_q;
        end

        // A flushed EXE entry is dropped instead of retiring into WB.
        if (!exeHold)
            wb_d = exeFlush ? PIPE_EMPTY : exe_q;
    end

    // Pipeline slots and stall-cause register.
    always_ff @(posedge CB or negedge resetCore_n) begin
        if (!resetCore_n) begin
            exe_q   <= PIPE_EMPTY;
            wb_q    <= PIPE_EMPTY;
            state_q <= ST_RUN;
        end else begin
            exe_q   <= exe_d;
            wb_q    <= wb_d;
            state_q <= state_d;
        end
    end

    assign stallReason  = state_q;
    assign exeCr0Busy   = exe_q.v & exe_q.cr0;
    assign exeLrCtrBusy = exe_q.v & exe_q.spr;

    p405s_dcd_sat_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk    (CB),
        .rst_n  (resetCore_n),
        .inc_en (dcdBrStall),
        .cnt    (brStallCnt)
    );

    // A stalled branch never also advances.
    a_stall_no_adv: assert property (@(posedge CB) disable iff (!resetCore_n)
        dcdBrStall |-> !dcdAdvance);

    // An unconditional branch on its own never interlocks.
    a_b_never_stalls: assert property (@(posedge CB) disable iff (!resetCore_n)
        (plaB && !plaBc) |-> !dcdBrStall);

endmodule

// File: tb/tb_p405s_dcd_br_hazard.sv
// Bench for p405s_dcd_br_hazard: directed scenarios plus randomized traffic
// checked against an in-flight-writer model. Two instances share stimulus:
// u_dut0 (no CR bypass, 4-bit counter) and u_dut1 (CR bypass, 8-bit counter).
module tb_p405s_dcd_br_hazard;

    logic CB = 1'b0;
    logic resetCore_n = 1'b0;
    logic dcdValid, plaCr0En, plaB, plaBc, plaMtspr, dcdSprLrCtr;
    logic dcdBcTestCr, dcdBcUseLrCtr, exeHold, exeFlush;

    logic       adv0, stall0, rok0, eb0, lb0;
    logic [1:0] rsn0;
    logic [3:0] cnt0;
    logic       adv1, stall1, rok1, eb1, lb1;
    logic [1:0] rsn1;
    logic [7:0] cnt1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CB = ~CB;

    p405s_dcd_br_hazard #(.CR_BYPASS(0), .CNT_W(4)) u_dut0 (
        .CB(CB), .resetCore_n(resetCore_n), .dcdValid(dcdValid),
        .plaCr0En(plaCr0En), .plaB(plaB), .plaBc(plaBc), .plaMtspr(plaMtspr),
        .dcdSprLrCtr(dcdSprLrCtr), .dcdBcTestCr(dcdBcTestCr),
        .dcdBcUseLrCtr(dcdBcUseLrCtr), .exeHold(exeHold), .exeFlush(exeFlush),
        .dcdAdvance(adv0), .dcdBrStall(stall0), .brResolveOk(rok0),
        .stallReason(rsn0), .exeCr0Busy(eb0), .exeLrCtrBusy(lb0),
        .brStallCnt(cnt0));

    p405s_dcd_br_hazard #(.CR_BYPASS(1), .CNT_W(8)) u_dut1 (
        .CB(CB), .resetCore_n(resetCore_n), .dcdValid(dcdValid),
        .plaCr0En(plaCr0En), .plaB(plaB), .plaBc(plaBc), .plaMtspr(plaMtspr),
        .dcdSprLrCtr(dcdSprLrCtr), .dcdBcTestCr(dcdBcTestCr),
        .dcdBcUseLrCtr(dcdBcUseLrCtr), .exeHold(exeHold), .exeFlush(exeFlush),
        .dcdAdvance(adv1), .dcdBrStall(stall1), .brResolveOk(rok1),
        .stallReason(rsn1), .exeCr0Busy(eb1), .exeLrCtrBusy(lb1),
        .brStallCnt(cnt1));

    // ---------------- reference model ----------------
    // Each in-flight instruction is a record with an age: 0 = one stage
    // past decode, 1 = two stages past decode. Writers retire after age 1.
    typedef struct {
        int inst;
        bit cr0;
        bit spr;
        int age;
    } rec_t;

    rec_t mq[$];
    int   mst[2];
    int   mcnt[2];
    int   bypass_of[2] = '{0, 1};
    int   cmax[2]      = '{15, 255};

    // {cr hazard, spr hazard} seen by the branch currently in decode.
    function automatic logic [1:0] haz(input int inst);
        bit crh = 1'b0;
        bit sph = 1'b0;
        foreach (mq[k]) begin
            if (mq[k].inst == inst) begin
                if (mq[k].cr0 && (mq[k].age == 0 || bypass_of[inst] == 0)) crh = 1'b1;
                if (mq[k].spr) sph = 1'b1;
            end
        end
        return {crh & dcdBcTestCr, sph & dcdBcUseLrCtr};
    endfunction

    // Expected {stall, advance, resolve, reason[1:0], cr0 busy, lr/ctr busy}.
    function automatic logic [6:0] exp_out(input int inst);
        logic [1:0] h;
        bit stall, adv, rok;
        bit eb = 1'b0;
        bit lb = 1'b0;
        h = haz(inst);
        foreach (mq[k]) begin
            if (mq[k].inst == inst && mq[k].age == 0) begin
                eb = eb | mq[k].cr0;
                lb = lb | mq[k].spr;
            end
        end
        stall = dcdValid & plaBc & (h[1] | h[0]);
        adv   = dcdValid & !stall & !exeHold & !exeFlush;
        rok   = dcdValid & !exeFlush & !stall & (plaB | plaBc);
        return {stall, adv, rok, 2'(mst[inst]), eb, lb};
    endfunction

    always @(posedge CB or negedge resetCore_n) begin
        rec_t       nq[$];
        rec_t       r;
        logic [6:0] e[2];
        logic [1:0] h[2];
        if (!resetCore_n) begin
            mq.delete();
            mst  = '{0, 0};
            mcnt = '{0, 0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                e[i] = exp_out(i);
                h[i] = haz(i);
            end
            nq.delete();
            foreach (mq[k]) begin
                r = mq[k];
                if (exeHold) begin
                    if (!(r.age == 0 && exeFlush)) nq.push_back(r);
                end else if (r.age == 0 && !exeFlush) begin
                    r.age = 1;
                    nq.push_back(r);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (e[i][5]) begin
                    r.inst = i;
                    r.cr0  = plaCr0En;
                    r.spr  = plaMtspr & dcdSprLrCtr;
                    r.age  = 0;
                    nq.push_back(r);
                end
                if (e[i][6]) begin
                    mst[i] = h[i][1] ? 1 : 2;
                    if (mcnt[i] < cmax[i]) mcnt[i] = mcnt[i] + 1;
                end else begin
                    mst[i] = 0;
                end
            end
            mq = nq;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        dcdValid = 0; plaCr0En = 0; plaB = 0; plaBc = 0; plaMtspr = 0;
        dcdSprLrCtr = 0; dcdBcTestCr = 0; dcdBcUseLrCtr = 0;
        exeHold = 0; exeFlush = 0;
    endtask

    task automatic apply_reset();
        idle();
        resetCore_n = 1'b0;
        repeat (2) @(negedge CB);
        resetCore_n = 1'b1;
    endtask

    task automatic cmpi();
        idle(); dcdValid = 1; plaCr0En = 1;
    endtask

    task automatic bc_cr();
        idle(); dcdValid = 1; plaBc = 1; dcdBcTestCr = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        resetCore_n = 1'b0;
        @(negedge CB); #1;
        n_chk++; if ({stall0, adv0, rok0, rsn0, eb0, lb0, cnt0} !== 11'd0) $display("FAIL reset_outs0: got %b want 0", {stall0, adv0, rok0, rsn0, eb0, lb0, cnt0}); else n_pass++;
        n_chk++; if ({stall1, rsn1, eb1, lb1, cnt1} !== 13'd0) $display("FAIL reset_outs1: got %b want 0", {stall1, rsn1, eb1, lb1, cnt1}); else n_pass++;
        bc_cr(); #1;
        n_chk++; if (rok0 !== 1'b1 || stall0 !== 1'b0) $display("FAIL reset_bc: rok=%b stall=%b want 1/0", rok0, stall0); else n_pass++;
        @(negedge CB);
        resetCore_n = 1'b1;
    endtask

    task automatic test_flush_priority();
        apply_reset();
        cmpi(); #1;
        n_chk++; if (adv0 !== 1'b1) $display("FAIL flush_cmpi_adv: got %b want 1", adv0); else n_pass++;
        @(negedge CB);
        bc_cr(); exeFlush = 1; #1;
        n_chk++; if (stall0 !== 1'b1) $display("FAIL flush_stall_seen: got %b want 1", stall0); else n_pass++;
        n_chk++; if (adv0 !== 1'b0 || rok0 !== 1'b0) $display("FAIL flush_adv_rok: adv=%b rok=%b want 0/0", adv0, rok0); else n_pass++;
        @(negedge CB);
        bc_cr(); #1;
        n_chk++; if (eb0 !== 1'b0) $display("FAIL flush_exe_clear: got %b want 0", eb0); else n_pass++;
        n_chk++; if (stall0 !== 1'b0 || adv0 !== 1'b1 || rok0 !== 1'b1) $display("FAIL flush_represent: stall=%b adv=%b rok=%b want 0/1/1", stall0, adv0, rok0); else n_pass++;
        @(negedge CB);
    endtask

    task automatic test_cr0_stall();
        apply_reset();
        cmpi(); @(negedge CB);
        bc_cr(); #1;
        n_chk++; if (stall0 !== 1'b1 || adv0 !== 1'b0 || rsn0 !== 2'b00) $display("FAIL cr_c1: stall=%b adv=%b rsn=%b want 1/0/00", stall0, adv0, rsn0); else n_pass++;
        n_chk++; if (stall1 !== 1'b1) $display("FAIL cr_byp_c1: got %b want 1", stall1); else n_pass++;
        @(negedge CB); #1;
        n_chk++; if (stall0 !== 1'b1 || rsn0 !== 2'b01) $display("FAIL cr_c2: stall=%b rsn=%b want 1/01", stall0, rsn0); else n_pass++;
        n_chk++; if (stall1 !== 1'b0 || adv1 !== 1'b1 || cnt1 !== 8'd1) $display("FAIL cr_byp_c2: stall=%b adv=%b cnt=%0d want 0/1/1", stall1, adv1, cnt1); else n_pass++;
        @(negedge CB); #1;
        n_chk++; if (stall0 !== 1'b0 || adv0 !== 1'b1 || rok0 !== 1'b1) $display("FAIL cr_c3: stall=%b adv=%b rok=%b want 0/1/1", stall0, adv0, rok0); else n_pass++;
        n_chk++; if (cnt0 !== 4'd2) $display("FAIL cr_cnt: got %0d want 2", cnt0); else n_pass++;
        @(negedge CB);
    endtask

    task automatic test_spr_hold();
        apply_reset();
        idle(); dcdValid = 1; plaMtspr = 1; dcdSprLrCtr = 1;
        @(negedge CB);
        for (int c = 0; c < 6; c++) begin
            idle(); dcdValid = 1; plaBc = 1; dcdBcUseLrCtr = 1;
            exeHold = (c < 3);
            #1;
            n_chk++; if (stall0 !== (c < 5)) $display("FAIL spr_stall_c%0d: got %b want %b", c, stall0, (c < 5)); else n_pass++;
            if (c >= 1 && c < 5) begin
                n_chk++; if (rsn0 !== 2'b10) $display("FAIL spr_rsn_c%0d: got %b want 10", c, rsn0); else n_pass++;
            end
            if (c < 4) begin
                n_chk++; if (lb0 !== 1'b1) $display("FAIL spr_busy_c%0d: got %b want 1", c, lb0); else n_pass++;
            end
            @(negedge CB);
        end
        #1;
        n_chk++; if (cnt0 !== 4'd5) $display("FAIL spr_cnt: got %0d want 5", cnt0); else n_pass++;
        idle(); dcdValid = 1; plaMtspr = 1; dcdSprLrCtr = 0;
        @(negedge CB);
        idle(); dcdValid = 1; plaBc = 1; dcdBcUseLrCtr = 1; #1;
        n_chk++; if (stall0 !== 1'b0 || lb0 !== 1'b0) $display("FAIL spr_other: stall=%b busy=%b want 0/0", stall0, lb0); else n_pass++;
        @(negedge CB);
    endtask

    task automatic test_uncond_branch();
        apply_reset();
        cmpi(); @(negedge CB);
        idle(); dcdValid = 1; plaB = 1; dcdBcTestCr = 1; #1;
        n_chk++; if (stall0 !== 1'b0 || rok0 !== 1'b1 || adv0 !== 1'b1) $display("FAIL uncond: stall=%b rok=%b adv=%b want 0/1/1", stall0, rok0, adv0); else n_pass++;
        @(negedge CB);
    endtask

    task automatic test_saturation_reset();
        apply_reset();
        cmpi(); @(negedge CB);
        for (int k = 0; k < 20; k++) begin
            bc_cr(); exeHold = 1; #1;
            n_chk++; if (stall0 !== 1'b1) $display("FAIL sat_stall_%0d: got %b want 1", k, stall0); else n_pass++;
            @(negedge CB);
        end
        bc_cr(); exeHold = 1; #1;
        n_chk++; if (cnt0 !== 4'd15) $display("FAIL sat_cnt4: got %0d want 15", cnt0); else n_pass++;
        n_chk++; if (cnt1 !== 8'd20) $display("FAIL sat_cnt8: got %0d want 20", cnt1); else n_pass++;
        #2 resetCore_n = 1'b0;
        #1;
        n_chk++; if ({stall0, adv0, rsn0, eb0, lb0, cnt0} !== 10'd0) $display("FAIL mid_reset: got %b want 0", {stall0, adv0, rsn0, eb0, lb0, cnt0}); else n_pass++;
        @(negedge CB);
        resetCore_n = 1'b1;
    endtask

    task automatic test_random();
        logic [6:0] e0, e1;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            dcdValid      = ($urandom_range(99) < 80);
            plaCr0En      = ($urandom_range(99) < 40);
            plaB          = ($urandom_range(99) < 15);
            plaBc         = ($urandom_range(99) < 40);
            plaMtspr      = ($urandom_range(99) < 30);
            dcdSprLrCtr   = ($urandom_range(99) < 50);
            dcdBcTestCr   = ($urandom_range(99) < 50);
            dcdBcUseLrCtr = ($urandom_range(99) < 50);
            exeHold       = ($urandom_range(99) < 15);
            exeFlush      = ($urandom_range(99) < 8);
            #1;
            e0 = exp_out(0);
            e1 = exp_out(1);
            n_chk++; if ({stall0, adv0, rok0, rsn0, eb0, lb0, 8'(cnt0)} !== {e0, 8'(mcnt[0])}) $display("FAIL rand0_c%0d: got %b/%0d want %b/%0d", c, {stall0, adv0, rok0, rsn0, eb0, lb0}, cnt0, e0, mcnt[0]); else n_pass++;
            n_chk++; if ({stall1, adv1, rok1, rsn1, eb1, lb1, cnt1} !== {e1, 8'(mcnt[1])}) $display("FAIL rand1_c%0d: got %b/%0d want %b/%0d", c, {stall1, adv1, rok1, rsn1, eb1, lb1}, cnt1, e1, mcnt[1]); else n_pass++;
            @(negedge CB);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_flush_priority();
        test_cr0_stall();
        test_spr_hold();
        test_uncond_branch();
        test_saturation_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
